// File: rtl/ppi_pkg.sv
// Shared types and encodings for the 8255A-style PPI core.
// Used by the port controllers and control-word decode.
package ppi_pkg;

  typedef enum logic [0:0] {
    IN_EMPTY = 1'b0,
    IN_FULL  = 1'b1
  } in_state_t;

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  localparam logic [1:0] GRP_MODE0 = 2'd0;
  localparam logic [1:0] GRP_MODE1 = 2'd1;
  localparam logic [1:0] GRP_MODE2 = 2'd2;

  localparam logic DIR_OUT = 1'b0;
  localparam logic DIR_IN  = 1'b1;

  // Port-C status bit positions for group A in mode 1
  localparam int PC_INTR_A  = 3;
  localparam int PC_IBF_A   = 5;
  localparam int PC_OBF_N_A = 7;

endpackage

// File: rtl/ppi_edge_sync.sv
// Multi-flop synchroniser for an active-low strobe with
// registered rise/fall pulses; resets to the idle-high level.
module ppi_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
    rise_d = ~prev_q & sync_q[STAGES-1];
    fall_d = prev_q & ~sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/ppi_port_a_strobed_io.sv
// Group-A Mode-1 strobed I/O controller for port A:
// STB/IBF input handshake, OBF/ACK output handshake, INTR.
module ppi_port_a_strobed_io #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_mode1,
  input  logic             cfg_dir_in,
  input  logic             inte,
  input  logic             rd_n,
  input  logic             wr_n,
  input  logic [WIDTH-1:0] int_din,
  output logic [WIDTH-1:0] int_dout,
  input  logic [WIDTH-1:0] pa_in,
  output logic [WIDTH-1:0] pa_out,
  output logic             pa_oe,
  input  logic             stb_n,
  input  logic             ack_n,
  output logic             ibf,
  output logic             obf_n,
  output logic             intr,
  output logic             overrun
);

  import ppi_pkg::*;

  logic stb_rise, stb_fall;
  logic ack_rise, ack_fall;
  logic rd_rise, rd_fall;
  logic wr_rise, wr_fall;

  ppi_edge_sync #(.STAGES(SYNC_STAGES)) u_stb (
    .clk(clk), .rst(rst), .d(stb_n),
    .rise(stb_rise), .fall(stb_fall)
  );
  ppi_edge_sync #(.STAGES(SYNC_STAGES)) u_ack (
    .clk(clk), .rst(rst), .d(ack_n),
    .rise(ack_rise), .fall(ack_fall)
  );
  ppi_edge_sync #(.STAGES(SYNC_STAGES)) u_rd (
    .clk(clk), .rst(rst), .d(rd_n),
    .rise(rd_rise), .fall(rd_fall)
  );
  ppi_edge_sync #(.STAGES(SYNC_STAGES)) u_wr (
    .clk(clk), .rst(rst), .d(wr_n),
    .rise(wr_rise), .fall(wr_fall)
  );

  // PA delay line keeps the latched sample aligned with the STB edge
  logic [SYNC_STAGES:0][WIDTH-1:0] pa_pipe_q, pa_pipe_d;

  in_state_t  in_q, in_d;
  out_state_t out_q, out_d;

  logic             obf_n_q, obf_n_d;
  logic             intr_q, intr_d;
  logic             ovr_q, ovr_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             oe_q, oe_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] pao_q, pao_d;

  logic cfg_chg;
  logic in_act;
  logic out_act;

  always_comb begin
    pa_pipe_d = {pa_pipe_q[SYNC_STAGES-1:0], pa_in};
    mode_d    = cfg_mode1;
    dir_d     = cfg_dir_in;
    oe_d      = cfg_mode1 & ~cfg_dir_in;
    in_d      = in_q;
    out_d     = out_q;
    obf_n_d   = obf_n_q;
    intr_d    = intr_q;
    ovr_d     = ovr_q;
    dout_d    = dout_q;
    pao_d     = pao_q;

    cfg_chg = (cfg_mode1 != mode_q) | (cfg_dir_in != dir_q);
    in_act  = cfg_mode1 & (cfg_dir_in == DIR_IN) & ~cfg_chg;
    out_act = cfg_mode1 & (cfg_dir_in == DIR_OUT) & ~cfg_chg;

    if (in_act) begin
      // A read completing frees the latch before a new strobe lands
      if (rd_rise) begin
        in_d  = IN_EMPTY;
        ovr_d = 1'b0;
      end
      if (stb_fall) begin
        if (in_d == IN_EMPTY) begin
          in_d   = IN_FULL;
          dout_d = pa_pipe_q[SYNC_STAGES];
        end else begin
          ovr_d = 1'b1;
        end
      end
      if (stb_rise && in_q == IN_FULL && inte) intr_d = 1'b1;
      if (rd_fall) intr_d = 1'b0;
    end else begin
      in_d  = IN_EMPTY;
      ovr_d = 1'b0;
    end

    if (out_act) begin
      if (wr_fall) intr_d = 1'b0;
      if (ack_fall && out_q == OUT_FULL) obf_n_d = 1'b1;
      if (ack_rise && obf_n_q && out_q == OUT_FULL) begin
        if (inte) intr_d = 1'b1;
        out_d = OUT_EMPTY;
      end
      // A CPU write beats a coincident acknowledge
      if (wr_rise) begin
        pao_d   = int_din;
        obf_n_d = 1'b0;
        out_d   = OUT_FULL;
      end
    end else begin
      out_d   = OUT_EMPTY;
      obf_n_d = 1'b1;
    end

    if (!(in_act || out_act) || !inte) intr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pa_pipe_q <= '0;
      mode_q    <= 1'b0;
      dir_q     <= 1'b0;
      oe_q      <= 1'b0;
      in_q      <= IN_EMPTY;
      out_q     <= OUT_EMPTY;
      obf_n_q   <= 1'b1;
      intr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      dout_q    <= '0;
      pao_q     <= '0;
    end else begin
      pa_pipe_q <= pa_pipe_d;
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      oe_q      <= oe_d;
      in_q      <= in_d;
      out_q     <= out_d;
      obf_n_q   <= obf_n_d;
      intr_q    <= intr_d;
      ovr_q     <= ovr_d;
      dout_q    <= dout_d;
      pao_q     <= pao_d;
    end
  end

  assign int_dout = dout_q;
  assign pa_out   = pao_q;
  assign pa_oe    = oe_q;
  assign ibf      = (in_q == IN_FULL);
  assign obf_n    = obf_n_q;
  assign intr     = intr_q;
  assign overrun  = ovr_q;

endmodule
